// File: rtl/tetris_piece_offsets.sv
// Cell-offset lookup for the falling O/I piece: (dx,dy) of four cells in the 4x4 box.
// Latency: 1 cycle when OUT_REG=1 (registered outputs), 0 cycles when OUT_REG=0.
// Backpressure: none; a new shape/rotation is accepted every cycle, with no stall or handshake.
//
// Ports:
//   clk, resetn     clock and asynchronous active-low reset (unused when OUT_REG=0)
//   shape_id        0 = O piece, 1 = I piece
//   rot             clockwise quarter turns, 0..3
//   dx0..dx3        column offsets of cells 0..3 (row-major cell order)
//   dy0..dy3        row offsets of cells 0..3 (0 = top row)
//   bb_xmin/ymin/xmax/ymax  tight bounding box of the four cells; these ports
//                   exist only when PIECE_OFFSETS_BBOX_EN is defined
module tetris_piece_offsets #(
  parameter bit OUT_REG = 1'b1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       shape_id,
  input  logic [1:0] rot,
  output logic [1:0] dx0,
  output logic [1:0] dx1,
  output logic [1:0] dx2,
  output logic [1:0] dx3,
  output logic [1:0] dy0,
  output logic [1:0] dy1,
  output logic [1:0] dy2,
  output logic [1:0] dy3
`ifdef PIECE_OFFSETS_BBOX_EN
  ,
  output logic [1:0] bb_xmin,
  output logic [1:0] bb_ymin,
  output logic [1:0] bb_xmax,
  output logic [1:0] bb_ymax
`endif
);

  typedef struct packed {
    logic [1:0] dx0, dx1, dx2, dx3;
    logic [1:0] dy0, dy1, dy2, dy3;
`ifdef PIECE_OFFSETS_BBOX_EN
    logic [1:0] xmin, ymin, xmax, ymax;
`endif
  } offs_t;

  offs_t lut_dat;
  offs_t out_dat;

  // Both horizontal I orientations list cells left to right along one row.
  // Both vertical orientations list them top to bottom down one column.
  always_comb begin
    lut_dat = '0;
    if (!shape_id) begin
      // O piece: the 2x2 block in the top-left corner, for every rotation.
      lut_dat.dx0 = 2'd0; lut_dat.dy0 = 2'd0;
      lut_dat.dx1 = 2'd1; lut_dat.dy1 = 2'd0;
      lut_dat.dx2 = 2'd0; lut_dat.dy2 = 2'd1;
      lut_dat.dx3 = 2'd1; lut_dat.dy3 = 2'd1;
`ifdef PIECE_OFFSETS_BBOX_EN
      lut_dat.xmin = 2'd0; lut_dat.ymin = 2'd0;
      lut_dat.xmax = 2'd1; lut_dat.ymax = 2'd1;
`endif
    end else begin
      case (rot)
        2'd0, 2'd2: begin
          // Horizontal: row 1 for rot 0, row 2 for rot 2.
          lut_dat.dx0 = 2'd0; lut_dat.dx1 = 2'd1;
          lut_dat.dx2 = 2'd2; lut_dat.dx3 = 2'd3;
          lut_dat.dy0 = rot[1] ? 2'd2 : 2'd1;
          lut_dat.dy1 = lut_dat.dy0;
          lut_dat.dy2 = lut_dat.dy0;
          lut_dat.dy3 = lut_dat.dy0;
`ifdef PIECE_OFFSETS_BBOX_EN
          lut_dat.xmin = 2'd0;        lut_dat.xmax = 2'd3;
          lut_dat.ymin = lut_dat.dy0; lut_dat.ymax = lut_dat.dy0;
`endif
        end
        default: begin
          // Vertical: column 2 for rot 1, column 1 for rot 3.
          lut_dat.dy0 = 2'd0; lut_dat.dy1 = 2'd1;
          lut_dat.dy2 = 2'd2; lut_dat.dy3 = 2'd3;
          lut_dat.dx0 = rot[1] ? 2'd1 : 2'd2;
          lut_dat.dx1 = lut_dat.dx0;
          lut_dat.dx2 = lut_dat.dx0;
          lut_dat.dx3 = lut_dat.dx0;
`ifdef PIECE_OFFSETS_BBOX_EN
          lut_dat.xmin = lut_dat.dx0; lut_dat.xmax = lut_dat.dx0;
          lut_dat.ymin = 2'd0;        lut_dat.ymax = 2'd3;
`endif
        end
      endcase
    end
  end

  generate
    if (OUT_REG) begin : g_reg
      offs_t q_dat;
      // Reset forces all offsets to zero; the first table value appears only
      // on the first rising edge after release.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) q_dat <= '0;
        else         q_dat <= lut_dat;
      end
      assign out_dat = q_dat;
    end else begin : g_comb
      assign out_dat = lut_dat;
    end
  endgenerate

  assign dx0 = out_dat.dx0;
  assign dx1 = out_dat.dx1;
  assign dx2 = out_dat.dx2;
  assign dx3 = out_dat.dx3;
  assign dy0 = out_dat.dy0;
  assign dy1 = out_dat.dy1;
  assign dy2 = out_dat.dy2;
  assign dy3 = out_dat.dy3;
`ifdef PIECE_OFFSETS_BBOX_EN
  assign bb_xmin = out_dat.xmin;
  assign bb_ymin = out_dat.ymin;
  assign bb_xmax = out_dat.xmax;
  assign bb_ymax = out_dat.ymax;
`endif

endmodule

// File: tb/tb_tetris_piece_offsets.sv
// Testbench for tetris_piece_offsets in its default build (OUT_REG=1).
// Combines a fixed-vector table, hand-written reset and latency sequences, and random traffic checked against a model.
// Inputs are driven at the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_tetris_piece_offsets;

  logic       clk;
  logic       resetn;
  logic       shape_id;
  logic [1:0] rot;
  logic [1:0] dx0, dx1, dx2, dx3, dy0, dy1, dy2, dy3;
`ifdef PIECE_OFFSETS_BBOX_EN
  logic [1:0] bb_xmin, bb_ymin, bb_xmax, bb_ymax;
`endif

  int total = 0;
  int bad   = 0;

  tetris_piece_offsets #(.OUT_REG(1'b1)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .shape_id (shape_id),
    .rot      (rot),
    .dx0      (dx0),
    .dx1      (dx1),
    .dx2      (dx2),
    .dx3      (dx3),
    .dy0      (dy0),
    .dy1      (dy1),
    .dy2      (dy2),
    .dy3      (dy3)
`ifdef PIECE_OFFSETS_BBOX_EN
    ,
    .bb_xmin  (bb_xmin),
    .bb_ymin  (bb_ymin),
    .bb_xmax  (bb_xmax),
    .bb_ymax  (bb_ymax)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Packed as {dx0,dx1,dx2,dx3,dy0,dy1,dy2,dy3}.
  function automatic logic [15:0] cur_out();
    return {dx0, dx1, dx2, dx3, dy0, dy1, dy2, dy3};
  endfunction

  // Reference: build the cell list geometrically, then pack it.
  function automatic logic [15:0] model(input bit s, input int r);
    int cx[4];
    int cy[4];
    logic [15:0] v;
    for (int i = 0; i < 4; i++) begin
      if (!s) begin
        cx[i] = i % 2;
        cy[i] = i / 2;
      end else if (r % 2 == 0) begin
        cx[i] = i;
        cy[i] = (r == 0) ? 1 : 2;
      end else begin
        cx[i] = (r == 1) ? 2 : 1;
        cy[i] = i;
      end
    end
    v = '0;
    for (int i = 0; i < 4; i++) begin
      v[15 - 2*i -: 2] = cx[i][1:0];
      v[7 - 2*i -: 2]  = cy[i][1:0];
    end
    return v;
  endfunction

`ifdef PIECE_OFFSETS_BBOX_EN
  function automatic logic [7:0] cur_bb();
    return {bb_xmin, bb_ymin, bb_xmax, bb_ymax};
  endfunction

  // Bounding box: min/max of the model's cells, as {xmin,ymin,xmax,ymax}.
  function automatic logic [7:0] model_bb(input bit s, input int r);
    logic [15:0] c;
    int xs[4];
    int ys[4];
    int xmn, xmx, ymn, ymx;
    c = model(s, r);
    for (int i = 0; i < 4; i++) begin
      xs[i] = int'(c[15 - 2*i -: 2]);
      ys[i] = int'(c[7 - 2*i -: 2]);
    end
    xmn = 3; ymn = 3; xmx = 0; ymx = 0;
    for (int i = 0; i < 4; i++) begin
      if (xs[i] < xmn) xmn = xs[i];
      if (xs[i] > xmx) xmx = xs[i];
      if (ys[i] < ymn) ymn = ys[i];
      if (ys[i] > ymx) ymx = ys[i];
    end
    return {xmn[1:0], ymn[1:0], xmx[1:0], ymx[1:0]};
  endfunction
`endif

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive at the falling edge, then sample just after the next rising edge.
  task automatic step(input bit s, input logic [1:0] r);
    @(negedge clk);
    shape_id = s;
    rot      = r;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          s;
    logic [1:0]  r;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b0, 2'd0, {2'd0,2'd1,2'd0,2'd1, 2'd0,2'd0,2'd1,2'd1}};
    vecs[1] = '{1'b0, 2'd1, {2'd0,2'd1,2'd0,2'd1, 2'd0,2'd0,2'd1,2'd1}};
    vecs[2] = '{1'b0, 2'd2, {2'd0,2'd1,2'd0,2'd1, 2'd0,2'd0,2'd1,2'd1}};
    vecs[3] = '{1'b0, 2'd3, {2'd0,2'd1,2'd0,2'd1, 2'd0,2'd0,2'd1,2'd1}};
    vecs[4] = '{1'b1, 2'd0, {2'd0,2'd1,2'd2,2'd3, 2'd1,2'd1,2'd1,2'd1}};
    vecs[5] = '{1'b1, 2'd1, {2'd2,2'd2,2'd2,2'd2, 2'd0,2'd1,2'd2,2'd3}};
    vecs[6] = '{1'b1, 2'd2, {2'd0,2'd1,2'd2,2'd3, 2'd2,2'd2,2'd2,2'd2}};
    vecs[7] = '{1'b1, 2'd3, {2'd1,2'd1,2'd1,2'd1, 2'd0,2'd1,2'd2,2'd3}};

    // Asynchronous reset, before any clock edge.
    resetn   = 1'b0;
    shape_id = 1'b1;
    rot      = 2'd1;
    #2;
    check("reset_async", cur_out(), 16'h0000);
    @(posedge clk);
    #1;
    check("reset_held_edge", cur_out(), 16'h0000);

    // Release reset away from the edge: outputs stay zero until a rising edge.
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("release_no_edge", cur_out(), 16'h0000);

    // Table sweep: O rotations, then I rotations, one per clock.
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].s, vecs[i].r);
      check($sformatf("table_s%0d_r%0d", vecs[i].s, vecs[i].r), cur_out(), vecs[i].exp);
    end

    // Latency: toggle shape 0->1 at rot=2; outputs change only after the edge.
    step(1'b0, 2'd2);
    check("toggle_o", cur_out(), vecs[2].exp);
    @(negedge clk);
    shape_id = 1'b1;
    #1;
    check("toggle_before_edge", cur_out(), vecs[2].exp);
    @(posedge clk);
    #1;
    check("toggle_i_row2", cur_out(), vecs[6].exp);

    // Reset asserted mid-sweep, then released.
    step(1'b1, 2'd3);
    check("mid_pre_reset", cur_out(), vecs[7].exp);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_reset_async", cur_out(), 16'h0000);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("mid_release_no_edge", cur_out(), 16'h0000);
    @(posedge clk);
    #1;
    check("mid_restore", cur_out(), vecs[7].exp);

`ifdef PIECE_OFFSETS_BBOX_EN
    step(1'b1, 2'd1);
    check("bb_i_rot1", {8'h00, cur_bb()}, {8'h00, 2'd2, 2'd0, 2'd2, 2'd3});
    step(1'b0, 2'd1);
    check("bb_o", {8'h00, cur_bb()}, {8'h00, 2'd0, 2'd0, 2'd1, 2'd1});
`endif

    // Random traffic, a new input every cycle, against the model.
    for (int n = 0; n < 300; n++) begin
      bit         s;
      logic [1:0] r;
      s = 1'($urandom_range(1, 0));
      r = 2'($urandom_range(3, 0));
      step(s, r);
      check($sformatf("rand%0d_s%0d_r%0d", n, s, r), cur_out(), model(s, int'(r)));
`ifdef PIECE_OFFSETS_BBOX_EN
      check($sformatf("rand_bb%0d", n), {8'h00, cur_bb()}, {8'h00, model_bb(s, int'(r))});
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
